// File: rtl/out_pair_if.sv
// Handshake/result bundle between a stimulus/monitor side and out_pair_checker.
// CHK_FIRST_FAIL_EN adds the first-failure capture signals.
interface out_pair_if #(parameter int CNT_W = 8);
    logic             start;
    logic             smp_valid;
    logic             out;
    logic             out_bar;
    logic             exp_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             cmp_err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] vec_count;
`ifdef CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] first_fail_idx;
    logic             first_fail_vld;

    modport master (
        output start, smp_valid, out, out_bar, exp_out,
        input  busy, done, pass, timeout, cmp_err, err_count, vec_count,
        input  first_fail_idx, first_fail_vld
    );
    modport slave (
        input  start, smp_valid, out, out_bar, exp_out,
        output busy, done, pass, timeout, cmp_err, err_count, vec_count,
        output first_fail_idx, first_fail_vld
    );
`else
    modport master (
        output start, smp_valid, out, out_bar, exp_out,
        input  busy, done, pass, timeout, cmp_err, err_count, vec_count
    );
    modport slave (
        input  start, smp_valid, out, out_bar, exp_out,
        output busy, done, pass, timeout, cmp_err, err_count, vec_count
    );
`endif
endinterface

// File: rtl/out_pair_checker.sv
// Response checker for an out/out_bar pair: run control, vector/error counts, watchdog.
// Optional macro CHK_FIRST_FAIL_EN adds first_fail_idx/first_fail_vld capture.
module out_pair_checker #(
    parameter int NUM_VECTORS = 7,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 8
) (
    input  logic      clk,
    input  logic      rst,
    out_pair_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] vec_q, vec_n, err_q, err_n;
    logic [WD_W-1:0]  wd_q, wd_n;
    logic             cmp_q, cmp_n, to_q, to_n;
    logic             busy_q, busy_n, done_q, done_n, pass_q, pass_n;
    logic             accept, mism, last;
`ifdef CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] ffi_q, ffi_n;
    logic             ffv_q, ffv_n;
`endif

    assign accept = (state_q == RUN) && bus.smp_valid;
    assign mism   = (bus.out != bus.exp_out) || (bus.out_bar == bus.out);
    assign last   = (vec_q + 1'b1) == CNT_W'(NUM_VECTORS);

    always_comb begin
        state_n = state_q;
        vec_n   = vec_q;
        err_n   = err_q;
        wd_n    = wd_q;
        cmp_n   = cmp_q;
        to_n    = to_q;
`ifdef CHK_FIRST_FAIL_EN
        ffi_n   = ffi_q;
        ffv_n   = ffv_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = RUN;
                    vec_n   = '0;
                    err_n   = '0;
                    wd_n    = '0;
                    cmp_n   = 1'b0;
                    to_n    = 1'b0;
`ifdef CHK_FIRST_FAIL_EN
                    ffi_n   = '0;
                    ffv_n   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (accept) begin
                    vec_n = vec_q + 1'b1;
                    wd_n  = '0;
                    if (mism && (err_q != '1))
                        err_n = err_q + 1'b1;
                    if (bus.out_bar == bus.out)
                        cmp_n = 1'b1;
`ifdef CHK_FIRST_FAIL_EN
                    if (mism && !ffv_q) begin
                        ffi_n = vec_q;
                        ffv_n = 1'b1;
                    end
`endif
                end else if (wd_q != WD_W'(TIMEOUT)) begin
                    wd_n = wd_q + 1'b1;
                end
                // A completing sample beats an expiring watchdog on the same edge.
                if (accept && last)
                    state_n = DONE;
                else if (wd_q == WD_W'(TIMEOUT)) begin
                    state_n = DONE;
                    to_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
        pass_n = done_n && (err_n == '0) && !to_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            wd_q    <= '0;
            cmp_q   <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef CHK_FIRST_FAIL_EN
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            vec_q   <= vec_n;
            err_q   <= err_n;
            wd_q    <= wd_n;
            cmp_q   <= cmp_n;
            to_q    <= to_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
`ifdef CHK_FIRST_FAIL_EN
            ffi_q   <= ffi_n;
            ffv_q   <= ffv_n;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.timeout   = to_q;
    assign bus.cmp_err   = cmp_q;
    assign bus.err_count = err_q;
    assign bus.vec_count = vec_q;
`ifdef CHK_FIRST_FAIL_EN
    assign bus.first_fail_idx = ffi_q;
    assign bus.first_fail_vld = ffv_q;
`endif
endmodule
